rename_map: RTL

Parametrised register-rename stage between decode and issue. Each accepted group of up to MAX_OPERANDS source and MAX_OPERANDS destination logical registers (LRNs) is translated to physical registers (PRNs). The block keeps a speculative LRN→PRN map table and a circular free-PRN FIFO, and returns the previous mapping of every destination so retire can free it. It adds valid/ready backpressure, real allocation, and recycling of up to FREE_PORTS PRNs per cycle.

---
 rtl/rename_map.sv | 116 +++++++++++
 1 files changed

// File: rtl/rename_map.sv
// rename_map: register rename stage with speculative map table, circular free-PRN FIFO and output register
module rename_map #(
  parameter int PRN_BITS     = 7,
  parameter int LRN_BITS     = 6,
  parameter int NUM_ARCH     = 62,
  parameter int MAX_OPERANDS = 3,
  parameter int FREE_PORTS   = 6,
  parameter int INVALID_LRN  = 62,
  parameter int ZERO_LRN     = 63
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             lrns_valid,
  output logic                             lrns_ready,
  input  logic [MAX_OPERANDS*LRN_BITS-1:0] lrn_input,
  input  logic [MAX_OPERANDS*LRN_BITS-1:0] lrn_output,
  input  logic [FREE_PORTS-1:0]            free_valid,
  input  logic [FREE_PORTS*PRN_BITS-1:0]   free_prns,
  output logic                             prns_valid,
  input  logic                             prns_ready,
  output logic [MAX_OPERANDS*PRN_BITS-1:0] prn_input,
  output logic [MAX_OPERANDS*PRN_BITS-1:0] prn_output,
  output logic [MAX_OPERANDS*PRN_BITS-1:0] prn_old,
  output logic [2*MAX_OPERANDS-1:0]        slot_live,
  output logic [PRN_BITS:0]                free_count
);
  localparam int NUM_PRN = 2 ** PRN_BITS;
  localparam int M = MAX_OPERANDS;
  localparam int CW = PRN_BITS + 1;
  logic [PRN_BITS-1:0] map_q [NUM_ARCH];
  logic [PRN_BITS-1:0] fifo_q [NUM_PRN];
  logic [PRN_BITS-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, need, pushes;
  logic [LRN_BITS-1:0] ls [M];
  logic [LRN_BITS-1:0] ld [M];
  logic [M-1:0] live_s, live_d;
  logic [M*PRN_BITS-1:0] src_p, dst_p, old_p;
  logic [PRN_BITS-1:0] push_addr [FREE_PORTS];
  logic accept;
  // Decode slots, read the pre-group map, pop PRNs in slot order and forward same-group writes into prn_old
  always_comb begin
    need = '0;
    src_p = '0;
    dst_p = '0;
    old_p = '0;
    for (int j = 0; j < M; j++) begin
      ls[j] = lrn_input[j*LRN_BITS +: LRN_BITS];
      ld[j] = lrn_output[j*LRN_BITS +: LRN_BITS];
      live_s[j] = ls[j] != LRN_BITS'(INVALID_LRN) && ls[j] != LRN_BITS'(ZERO_LRN);
      live_d[j] = ld[j] != LRN_BITS'(INVALID_LRN) && ld[j] != LRN_BITS'(ZERO_LRN);
      src_p[j*PRN_BITS +: PRN_BITS] = live_s[j] ? map_q[ls[j]] : '0;
      dst_p[j*PRN_BITS +: PRN_BITS] = live_d[j] ? fifo_q[head_q + PRN_BITS'(need)] : '0;
      old_p[j*PRN_BITS +: PRN_BITS] = live_d[j] ? map_q[ld[j]] : '0;
      for (int k = 0; k < j; k++)
        if (live_d[k] && live_d[j] && ld[k] == ld[j]) old_p[j*PRN_BITS +: PRN_BITS] = dst_p[k*PRN_BITS +: PRN_BITS];
      need = need + CW'(live_d[j]);
    end
  end
  // Tail slot for each asserted free port, packed in port order
  always_comb begin
    pushes = '0;
    for (int p = 0; p < FREE_PORTS; p++) begin
      push_addr[p] = tail_q + PRN_BITS'(pushes);
      pushes = pushes + CW'(free_valid[p]);
    end
  end
  assign lrns_ready = (!prns_valid || prns_ready) && count_q >= need;
  assign accept = lrns_valid && lrns_ready;
  assign free_count = count_q;
  // Map table and FIFO pointers; later slots overwrite earlier ones on duplicate destinations
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) map_q[i] <= PRN_BITS'(i);
      head_q <= '0;
      tail_q <= PRN_BITS'(NUM_PRN - NUM_ARCH);
      count_q <= CW'(NUM_PRN - NUM_ARCH);
    end else begin
      if (accept)
        for (int j = 0; j < M; j++)
          if (live_d[j]) map_q[ld[j]] <= dst_p[j*PRN_BITS +: PRN_BITS];
      head_q <= head_q + (accept ? PRN_BITS'(need) : '0);
      tail_q <= tail_q + PRN_BITS'(pushes);
      count_q <= count_q + pushes - (accept ? need : '0);
    end
  end
  // Free-PRN storage: reset image holds the non-architectural PRNs in ascending order
  always_ff @(posedge clk) begin
    if (rst)
      for (int i = 0; i < NUM_PRN; i++) fifo_q[i] <= PRN_BITS'(i + NUM_ARCH);
    else
      for (int p = 0; p < FREE_PORTS; p++)
        if (free_valid[p]) fifo_q[push_addr[p]] <= free_prns[p*PRN_BITS +: PRN_BITS];
  end
  // Output register: load on accept, hold while stalled, drop valid once drained
  always_ff @(posedge clk) begin
    if (rst) begin
      prns_valid <= 1'b0;
      prn_input <= '0;
      prn_output <= '0;
      prn_old <= '0;
      slot_live <= '0;
    end else if (accept) begin
      prns_valid <= 1'b1;
      prn_input <= src_p;
      prn_output <= dst_p;
      prn_old <= old_p;
      slot_live <= {live_d, live_s};
    end else if (prns_ready) begin
      prns_valid <= 1'b0;
    end
  end
  // PRNs are conserved, so the FIFO can never be pushed past capacity
  always_ff @(posedge clk) begin
    if (!rst) assert (int'(count_q) + int'(pushes) <= NUM_PRN);
  end
endmodule
